// File: rtl/sprite_pkg.sv
// Shared state encoding and geometry constants for the sprite draw scheduler.
package sprite_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam int SPRITE_DIM   = 16;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOUR_W = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after pointer (wrapping), one-hot grant plus index.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;

  // Rotate so bit 0 is the pointer position; scan high-to-low so the nearest offset wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    sum    = '0;
    rot    = NUM_REQ'({req, req} >> pointer);
    if (enable) begin
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
        if (rot[j]) begin
          sum = {1'b0, pointer} + (IDX_W + 1)'(j);
          if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
          winner = sum[IDX_W-1:0];
        end
      end
      if (|rot) grant = NUM_REQ'(1) << winner;
    end
  end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// Arbitrates draw requesters, sweeps one 16x16 sprite through the ROM and plots it with clipping.
// Define SPRITE_TRANSPARENCY_EN to suppress pixels whose colour equals TRANSPARENT_COLOUR.
module sprite_draw_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int SPR_W    = 2,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ROM_LAT  = 1,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = '0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*SPR_W-1:0] req_sprite,
  output logic [NUM_REQ-1:0]       grant,
  output logic [SPR_W+7:0]         rom_addr,
  input  logic [COLOUR_W-1:0]      rom_data,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COLOUR_W-1:0]      vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     done
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef struct packed {
    logic           vld;
    logic           on;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    ptr, winner;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [X_W-1:0]      base_x, sel_x, hold_x;
  logic [Y_W-1:0]      base_y, sel_y, hold_y;
  logic [SPR_W-1:0]    spr, sel_spr;
  logic [COLOUR_W-1:0] hold_c;
  logic [3:0]          col, row;
  logic [DW-1:0]       drain_cnt;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  pix_t                issue, head;
  pix_t                pipe [ROM_LAT];
  logic                head_plot;

  // Gating with resetn keeps grant low while reset is held even if requests are up.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .pointer (ptr),
    .enable  ((state == IDLE) && resetn),
    .grant   (arb_grant),
    .winner  (winner)
  );

  assign grant = arb_grant;

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_spr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_x   = req_x[i*X_W +: X_W];
        sel_y   = req_y[i*Y_W +: Y_W];
        sel_spr = req_sprite[i*SPR_W +: SPR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|arb_grant) state_nxt = SWEEP;
      SWEEP:   if (row == 4'(SPRITE_DIM - 1) && col == 4'(SPRITE_DIM - 1)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DW'(ROM_LAT - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr       <= '0;
      base_x    <= '0;
      base_y    <= '0;
      spr       <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|arb_grant) begin
          base_x    <= sel_x;
          base_y    <= sel_y;
          spr       <= sel_spr;
          ptr       <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          col       <= '0;
          row       <= '0;
          drain_cnt <= '0;
        end
        SWEEP: begin
          col <= col + 1'b1;
          if (col == 4'(SPRITE_DIM - 1)) row <= row + 1'b1;
        end
        DRAIN:   drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // One extra bit on the sums so off-screen pixels never alias back onto the screen.
  assign sum_x = {1'b0, base_x} + (X_W + 1)'(col);
  assign sum_y = {1'b0, base_y} + (Y_W + 1)'(row);

  always_comb begin
    issue.vld = (state == SWEEP);
    issue.on  = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
    issue.x   = sum_x[X_W-1:0];
    issue.y   = sum_y[Y_W-1:0];
  end

  // Coordinates travel alongside the ROM read so the head lines up with rom_data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign head = pipe[ROM_LAT-1];

`ifdef SPRITE_TRANSPARENCY_EN
  assign head_plot = head.vld && head.on && (rom_data != TRANSPARENT_COLOUR);
`else
  logic unused_key;
  assign unused_key = ^TRANSPARENT_COLOUR;
  assign head_plot  = head.vld && head.on;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_x <= '0;
      hold_y <= '0;
      hold_c <= '0;
    end else if (head_plot) begin
      hold_x <= head.x;
      hold_y <= head.y;
      hold_c <= rom_data;
    end
  end

  assign vga_plot   = head_plot;
  assign vga_x      = head_plot ? head.x   : hold_x;
  assign vga_y      = head_plot ? head.y   : hold_y;
  assign vga_colour = head_plot ? rom_data : hold_c;
  assign rom_addr   = {spr, row, col};
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench: table of single-sprite vectors plus reset, back-to-back and latency sequences.
`timescale 1ns/1ps
module tb_sprite_draw_scheduler;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam int TRANS_PLOTS = 216;
`else
  localparam int TRANS_PLOTS = 256;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [1:0] req1, req3;
  logic [7:0] rx [2];
  logic [6:0] ry [2];
  logic [1:0] rs [2];
  logic [15:0] req_x_w;
  logic [13:0] req_y_w;
  logic [3:0]  req_s_w;
  assign req_x_w = {rx[1], rx[0]};
  assign req_y_w = {ry[1], ry[0]};
  assign req_s_w = {rs[1], rs[0]};

  logic [1:0] g1, g3;
  logic [9:0] a1, a3;
  logic [2:0] d1, d3, c1, c3, q3a, q3b;
  logic [7:0] x1, x3;
  logic [6:0] y1, y3;
  logic       p1, p3, b1, b3, dn1, dn3;

  sprite_draw_scheduler #(.ROM_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .req(req1), .req_x(req_x_w), .req_y(req_y_w),
    .req_sprite(req_s_w), .grant(g1), .rom_addr(a1), .rom_data(d1), .vga_x(x1),
    .vga_y(y1), .vga_colour(c1), .vga_plot(p1), .busy(b1), .done(dn1));

  sprite_draw_scheduler #(.ROM_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .req(req3), .req_x(req_x_w), .req_y(req_y_w),
    .req_sprite(req_s_w), .grant(g3), .rom_addr(a3), .rom_data(d3), .vga_x(x3),
    .vga_y(y3), .vga_colour(c3), .vga_plot(p3), .busy(b3), .done(dn3));

  int mode;

  // ROM contents: never zero, except the last 40 pixels of every sprite in mode 1.
  function automatic logic [2:0] pix_colour(input int m, input logic [1:0] s,
                                            input logic [3:0] r, input logic [3:0] c);
    int idx;
    idx = int'(r) * 16 + int'(c);
    if (m == 1 && idx >= 216) return 3'd0;
    return 3'(((int'(c) + 2 * int'(r) + int'(s)) % 7) + 1);
  endfunction

  always @(posedge clk) d1 <= pix_colour(mode, a1[9:8], a1[7:4], a1[3:0]);
  always @(posedge clk) begin
    q3a <= pix_colour(mode, a3[9:8], a3[7:4], a3[3:0]);
    q3b <= q3a;
    d3  <= q3b;
  end

  logic       sel3;
  logic [1:0] m_grant;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_col;
  logic       m_plot, m_done;
  assign m_grant = sel3 ? g3 : g1;
  assign m_x     = sel3 ? x3 : x1;
  assign m_y     = sel3 ? y3 : y1;
  assign m_col   = sel3 ? c3 : c1;
  assign m_plot  = sel3 ? p3 : p1;
  assign m_done  = sel3 ? dn3 : dn1;

  int    checks = 0;
  int    failures = 0;
  string bad_msg;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_pix(input string name, input int bad);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d pixel errors, first %s", name, bad, bad_msg);
    end
  endtask

  // Waits for a grant, then follows the sprite until done, checking every plot against
  // the coordinates and sprite latched at grant time.
  task automatic serve(input int lat, input bit drop, output logic [1:0] g, output int gap,
                       output int plots, output int first, output int done_c, output int bad);
    int w, k, p, wi;
    logic [7:0] bx;
    logic [6:0] by;
    logic [1:0] bs;
    logic [3:0] r, c;
    g = '0; gap = -1; plots = 0; first = -1; done_c = -1; bad = 0;
    for (w = 0; w < 60; w++) begin
      if (m_grant != 2'b00) break;
      @(negedge clk); #1;
    end
    if (m_grant == 2'b00) return;
    gap = w;
    g = m_grant;
    wi = m_grant[1] ? 1 : 0;
    bx = rx[wi]; by = ry[wi]; bs = rs[wi];
    for (k = 1; k < 400; k++) begin
      @(negedge clk); #1;
      if (k == 1 && drop) begin req1 = 2'b00; req3 = 2'b00; end
      if (k == 2) begin rx[wi] ^= 8'h40; rs[wi] ^= 2'b01; end
      if (m_plot) begin
        p = k - 1 - lat;
        plots++;
        if (first < 0) first = k;
        if (p < 0 || p > 255) begin
          bad++;
          if (bad == 1) bad_msg = $sformatf("plot outside sweep at cycle %0d", k);
        end else begin
          r = 4'(p / 16);
          c = 4'(p % 16);
          if (m_x !== bx + 8'(c) || m_y !== by + 7'(r) || m_col !== pix_colour(mode, bs, r, c)) begin
            bad++;
            if (bad == 1)
              bad_msg = $sformatf("cycle %0d got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)", k, m_x, m_y,
                                  m_col, bx + 8'(c), by + 7'(r), pix_colour(mode, bs, r, c));
          end
        end
      end
      if (m_done) begin done_c = k; break; end
    end
  endtask

  typedef struct {
    logic [1:0] req;
    bit         use3;
    int         mode;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] spr;
    logic [1:0] exp_grant;
    int         exp_plots;
    int         exp_first;
    int         exp_done;
  } vec_t;

  initial begin
    vec_t vt [6];
    logic [1:0] g;
    int gap, plots, first, done_c, bad, w, seen_done, got_grant;

    vt[0] = '{2'b01, 1'b0, 0, 8'd10,  7'd20,  2'd1, 2'b01, 256,         2, 258};
    vt[1] = '{2'b01, 1'b0, 0, 8'd150, 7'd110, 2'd2, 2'b01, 100,         2, 258};
    vt[2] = '{2'b10, 1'b0, 1, 8'd0,   7'd0,   2'd3, 2'b10, TRANS_PLOTS, 2, 258};
    vt[3] = '{2'b11, 1'b0, 0, 8'd152, 7'd112, 2'd0, 2'b01, 64,          2, 258};
    vt[4] = '{2'b01, 1'b1, 0, 8'd10,  7'd20,  2'd0, 2'b01, 256,         4, 260};
    vt[5] = '{2'b11, 1'b0, 0, 8'd30,  7'd40,  2'd2, 2'b10, 256,         2, 258};

    resetn = 1'b0; req1 = 2'b00; req3 = 2'b00; sel3 = 1'b0; mode = 0; bad_msg = "";
    rx[0] = 8'd0; rx[1] = 8'd0; ry[0] = 7'd0; ry[1] = 7'd0; rs[0] = 2'd0; rs[1] = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", int'(|{g1, a1, x1, y1, c1, p1, b1, dn1}), 0);
    check("reset outputs lat3", int'(|{g3, a3, x3, y3, c3, p3, b3, dn3}), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      mode = vt[i].mode;
      w = vt[i].exp_grant[1] ? 1 : 0;
      rx[w] = vt[i].x; ry[w] = vt[i].y; rs[w] = vt[i].spr;
      rx[1-w] = 8'd200; ry[1-w] = 7'd100; rs[1-w] = 2'd3;
      sel3 = vt[i].use3;
      if (vt[i].use3) req3 = vt[i].req; else req1 = vt[i].req;
      #1;
      serve(vt[i].use3 ? 3 : 1, 1'b1, g, gap, plots, first, done_c, bad);
      check($sformatf("v%0d grant", i), int'(g), int'(vt[i].exp_grant));
      check($sformatf("v%0d plots", i), plots, vt[i].exp_plots);
      check($sformatf("v%0d first plot", i), first, vt[i].exp_first);
      check($sformatf("v%0d done cycle", i), done_c, vt[i].exp_done);
      check_pix($sformatf("v%0d pixels", i), bad);
      @(negedge clk); #1;
      check($sformatf("v%0d idle after", i), int'({m_grant, sel3 ? b3 : b1}), 0);
    end

    // Reset in the middle of a sweep abandons the sprite; the pointer restarts at 0.
    @(negedge clk); #1;
    sel3 = 1'b0; mode = 0;
    rx[0] = 8'd10; ry[0] = 7'd20; rs[0] = 2'd1;
    rx[1] = 8'd40; ry[1] = 7'd60; rs[1] = 2'd2;
    req1 = 2'b01; #1;
    got_grant = 0;
    for (int j = 0; j < 10; j++) begin
      if (g1 != 2'b00) begin got_grant = 1; break; end
      @(negedge clk); #1;
    end
    check("midreset first grant", got_grant, 1);
    @(negedge clk); #1;
    req1 = 2'b00;
    repeat (98) @(negedge clk);
    #1;
    check("midreset busy before", int'(b1), 1);
    @(negedge clk);
    resetn = 1'b0; req1 = 2'b10; #1;
    check("midreset outputs", int'(|{g1, a1, x1, y1, c1, p1, b1, dn1}), 0);
    seen_done = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      if (dn1 || p1 || g1 != 2'b00) seen_done++;
    end
    check("midreset quiet", seen_done, 0);
    @(negedge clk);
    resetn = 1'b1; #1;
    serve(1, 1'b1, g, gap, plots, first, done_c, bad);
    check("after reset grant", int'(g), 2);
    check("after reset plots", plots, 256);
    check("after reset done cycle", done_c, 258);
    check_pix("after reset pixels", bad);

    // Both requesters held: grants alternate with one idle cycle between sprites.
    @(negedge clk); #1;
    rx[0] = 8'd10; ry[0] = 7'd20; rs[0] = 2'd0;
    rx[1] = 8'd20; ry[1] = 7'd30; rs[1] = 2'd3;
    req1 = 2'b11; #1;
    for (int j = 0; j < 3; j++) begin
      serve(1, 1'b0, g, gap, plots, first, done_c, bad);
      check($sformatf("b2b%0d grant", j), int'(g), (j == 1) ? 2 : 1);
      check($sformatf("b2b%0d plots", j), plots, 256);
      check($sformatf("b2b%0d first plot", j), first, 2);
      check($sformatf("b2b%0d done cycle", j), done_c, 258);
      check_pix($sformatf("b2b%0d pixels", j), bad);
      if (j > 0) check($sformatf("b2b%0d idle gap", j), gap, 1);
    end
    req1 = 2'b00;
    @(negedge clk); #1;
    check("b2b idle after", int'({g1, b1}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
